// File: rtl/fp_round_pkg.sv
// Shared types and helpers for the floating-point rounding datapath.
package fp_round_pkg;

    // Rounding modes carried with each beat
    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RUP = 3'd2,
        RDN = 3'd3,
        RMM = 3'd4
    } rnd_mode_t;

    // Output classification
    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_t;

    // Map the raw 3-bit mode field onto a legal mode; unused codes fall back to RNE
    function automatic rnd_mode_t legal_mode(input logic [2:0] raw);
        rnd_mode_t m;
        case (raw)
            3'd1:    m = RTZ;
            3'd2:    m = RUP;
            3'd3:    m = RDN;
            3'd4:    m = RMM;
            default: m = RNE;
        endcase
        return m;
    endfunction

    // Decide whether the mantissa must be incremented by one ulp
    function automatic logic round_inc(input rnd_mode_t mode,
                                       input logic      sign,
                                       input logic      lsb,
                                       input logic      r,
                                       input logic      s);
        logic inc;
        case (mode)
            RTZ:     inc = 1'b0;
            RUP:     inc = (r | s) & ~sign;
            RDN:     inc = (r | s) & sign;
            RMM:     inc = r;
            default: inc = r & (s | lsb);
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier: biased exponent and mantissa -> NORMAL/ZERO/INF/NAN.
module fp_classify
    import fp_round_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic [EXP_W-1:0]  expo,
    input  logic [MANT_W-1:0] mant,
    output fp_class_t         cls
);

    // All-ones exponent encodes Inf/NaN, split by the fraction field
    always_comb begin
        cls = CLS_NORMAL;
        if (&expo) begin
            cls = (|mant[MANT_W-2:0]) ? CLS_NAN : CLS_INF;
        end else if ((expo == '0) && (mant == '0)) begin
            cls = CLS_ZERO;
        end
    end

endmodule

// File: rtl/float_round_unit.sv
// Two-stage rounding unit: S1 decides the increment and adds it, S2 renormalises
// a mantissa carry, saturates on exponent overflow and classifies the result.
module float_round_unit
    import fp_round_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_guard,
    input  logic              in_sticky,
    input  logic              in_zero,
    input  logic [2:0]        rnd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_inexact,
    output logic              out_overflow,
    output logic [1:0]        out_class
);

    localparam logic [EXP_W-1:0]  EXP_ALL1 = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]  EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MANT_W-1:0] MANT_MAX = {MANT_W{1'b1}};

    // Overflow result: Inf or the largest finite value, depending on direction of rounding
    function automatic logic [EXP_W+MANT_W-1:0] sat_result(input rnd_mode_t mode,
                                                            input logic      sign);
        logic to_inf;
        case (mode)
            RTZ:     to_inf = 1'b0;
            RUP:     to_inf = ~sign;
            RDN:     to_inf = sign;
            default: to_inf = 1'b1;
        endcase
        return to_inf ? {EXP_ALL1, {MANT_W{1'b0}}} : {EXP_MAXF, MANT_MAX};
    endfunction

    logic en1, en2;

    // S1 registers
    logic              vld_p1;
    logic              sign_p1;
    logic [EXP_W-1:0]  exp_p1;
    logic [MANT_W:0]   sum_p1;
    rnd_mode_t         mode_p1;
    logic              inexact_p1;

    // S2 registers
    logic              vld_p2;
    logic              sign_p2;
    logic [EXP_W-1:0]  exp_p2;
    logic [MANT_W-1:0] mant_p2;
    logic              inexact_p2;
    logic              overflow_p2;
    fp_class_t         class_p2;

    // A stage may load when it is empty or its contents move on this cycle
    assign en2      = !vld_p2 | out_ready;
    assign en1      = !vld_p1 | en2;
    assign in_ready = en1;

    // ---- Stage 0 -> S1: increment decision and add ----
    rnd_mode_t         mode_p0;
    logic              special_p0;
    logic              inc_p0;
    logic              sign_p0;
    logic [EXP_W-1:0]  exp_p0;
    logic [MANT_W:0]   sum_p0;
    logic              inexact_p0;

    assign mode_p0    = legal_mode(rnd_mode);
    assign special_p0 = &in_exp;

    // Zero and Inf/NaN inputs bypass rounding; everything else adds the increment
    always_comb begin
        inc_p0     = 1'b0;
        sign_p0    = in_sign;
        exp_p0     = in_exp;
        sum_p0     = {1'b0, in_mant};
        inexact_p0 = 1'b0;
        if (in_zero) begin
            sign_p0 = (mode_p0 == RDN);
            exp_p0  = '0;
            sum_p0  = '0;
        end else if (!special_p0) begin
            inc_p0     = round_inc(mode_p0, in_sign, in_mant[0], in_guard, in_sticky);
            sum_p0     = {1'b0, in_mant} + {{MANT_W{1'b0}}, inc_p0};
            inexact_p0 = in_guard | in_sticky;
        end
    end

    // S1 pipeline register, advances when the stage can accept
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            vld_p1     <= 1'b0;
            sign_p1    <= 1'b0;
            exp_p1     <= '0;
            sum_p1     <= '0;
            mode_p1    <= RNE;
            inexact_p1 <= 1'b0;
        end else if (en1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sign_p1    <= sign_p0;
                exp_p1     <= exp_p0;
                sum_p1     <= sum_p0;
                mode_p1    <= mode_p0;
                inexact_p1 <= inexact_p0;
            end
        end
    end

    // ---- S1 -> S2: carry renormalisation, overflow saturation, classify ----
    logic              carry_p1;
    logic [EXP_W:0]    exp_inc_p1;
    logic [EXP_W-1:0]  exp_res_p1;
    logic [MANT_W-1:0] mant_res_p1;
    logic              inexact_res_p1;
    logic              overflow_res_p1;
    fp_class_t         class_res_p1;

    assign carry_p1   = sum_p1[MANT_W];
    assign exp_inc_p1 = {1'b0, exp_p1} + {{EXP_W{1'b0}}, 1'b1};

    // A carry out of the mantissa shifts right by one and bumps the exponent
    always_comb begin
        exp_res_p1      = exp_p1;
        mant_res_p1     = sum_p1[MANT_W-1:0];
        inexact_res_p1  = inexact_p1;
        overflow_res_p1 = 1'b0;
        if (carry_p1) begin
            mant_res_p1 = sum_p1[MANT_W:1];
            exp_res_p1  = exp_inc_p1[EXP_W-1:0];
            if (exp_inc_p1[EXP_W-1:0] == EXP_ALL1) begin
                overflow_res_p1             = 1'b1;
                inexact_res_p1              = 1'b1;
                {exp_res_p1, mant_res_p1}   = sat_result(mode_p1, sign_p1);
            end
        end
    end

    fp_classify #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W)
    ) u_classify (
        .expo (exp_res_p1),
        .mant (mant_res_p1),
        .cls  (class_res_p1)
    );

    // S2 pipeline register, held while the downstream stalls
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            vld_p2      <= 1'b0;
            sign_p2     <= 1'b0;
            exp_p2      <= '0;
            mant_p2     <= '0;
            inexact_p2  <= 1'b0;
            overflow_p2 <= 1'b0;
            class_p2    <= CLS_NORMAL;
        end else if (en2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                sign_p2     <= sign_p1;
                exp_p2      <= exp_res_p1;
                mant_p2     <= mant_res_p1;
                inexact_p2  <= inexact_res_p1;
                overflow_p2 <= overflow_res_p1;
                class_p2    <= class_res_p1;
            end
        end
    end

    assign out_valid    = vld_p2;
    assign out_sign     = sign_p2;
    assign out_exp      = exp_p2;
    assign out_mant     = mant_p2;
    assign out_inexact  = inexact_p2;
    assign out_overflow = overflow_p2;
    assign out_class    = class_p2;

endmodule
